muscle_sweep_scheduler: RTL and testbench
=========================================

# muscle_sweep_scheduler

Tick-driven scheduler that time-multiplexes one shared, pipelined muscle-update datapath (twitch filter + total-force integrator) across N_CH muscle channels. On each simulation tick it issues every enabled channel once, in index order, to the datapath. It presents that channel's per-channel twitch time constant `tau` and generates the matching write-back strobe LAT cycles later for the external state bank. It also reports sweep completion and flags ticks that arrive while a sweep is still running.

## Interface
Parameters:
- N_CH, 8, number of muscle channels (2..256)
- CH_W, 3, channel index width, ≥ ceil(log2(N_CH))
- LAT, 4, datapath latency in cycles from issue to result (≥ 1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- tick  in  1  sweep request; sampled every cycle
- en_mask  in  N_CH  per-channel enable; snapshotted when a tick is accepted
- cfg_we  in  1  tau write strobe
- cfg_addr  in  CH_W  tau write channel
- cfg_data  in  32  tau value, IEEE-754 single, in seconds
- issue_valid  out  1  channel presented to the datapath this cycle
- issue_ch  out  CH_W  issued channel index
- f_tau_out  out  32  tau[issue_ch]; 0 when issue_valid=0
- wb_valid  out  1  datapath result valid; external bank writes its state
- wb_ch  out  CH_W  write-back channel index
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse when a sweep fully completes
- overrun  out  1  sticky: a tick was dropped
- tick_drop_cnt  out  16  count of dropped ticks, saturating

## Operation
- State machine states and transitions:
  - IDLE. tick=1 → latch en_mask into mask_q, ch_cnt←0, go to ISSUE.
  - ISSUE. Lasts N_CH cycles, one channel per cycle.
    - Per cycle: issue_valid=mask_q[ch_cnt], issue_ch=ch_cnt, f_tau_out=tau[ch_cnt] when issuing.
    - A masked channel still consumes its cycle, so sweep timing is fixed.
    - At ch_cnt=N_CH-1 → DRAIN, with a drain counter loaded with LAT.
  - DRAIN. Lasts LAT cycles, then → DONE.
  - DONE. Lasts 1 cycle with done=1, then → IDLE.
- busy=1 in ISSUE, DRAIN and DONE.
- Write-back: a LAT-deep shift register carries {valid, ch}.
  - wb_valid/wb_ch equal issue_valid/issue_ch exactly LAT cycles earlier.
  - Masked channels never produce a write-back.
- Dropped ticks: tick=1 while busy=1 drops that tick.
  - overrun←1.
  - tick_drop_cnt increments and saturates at 0xFFFF.
  - Both clear only on reset.
- en_mask changes during a sweep have no effect until the next accepted tick.
- tau register file: N_CH × 32.
  - cfg_we writes tau[cfg_addr] at the clock edge, in any state.
  - cfg_addr ≥ N_CH is ignored.
  - A write to the channel being issued in the same cycle does not affect this cycle's f_tau_out; the new value is visible next cycle.
- Reset values:
  - FSM=IDLE.
  - All outputs 0.
  - Write-back pipe cleared.
  - mask_q=0.
  - Every tau entry = 32'h3D23D70A (0.04 s).
- Reset asserted mid-sweep aborts the sweep immediately. No pending write-back or done is emitted after reset releases.
- No floating-point arithmetic is performed in this block. tau is passed through unmodified.

## Timing
Take an accepted tick sampled at edge t:
- ISSUE occupies cycles t+1 … t+N_CH; channel k issues at cycle t+1+k.
- Write-back for channel k occurs at cycle t+1+k+LAT. The last write-back is at t+N_CH+LAT.
- DRAIN occupies t+N_CH+1 … t+N_CH+LAT.
- done=1 at cycle t+N_CH+LAT+1.
- IDLE is reached at t+N_CH+LAT+2. The earliest next accepted tick is sampled at that cycle.
- Minimum tick period: N_CH+LAT+2 cycles.
- A tick coincident with done is dropped.
- Outputs are register-driven. There is no combinational path from tick, en_mask or cfg_* to any output.

## Test plan
- Full sweep, default parameters (N_CH=8, LAT=4), en_mask=8'hFF, tick at t=10:
  - issue_ch 0..7 on cycles 11..18;
  - wb_ch 0..7 on cycles 15..22;
  - done only at cycle 23;
  - busy high for cycles 11..23.
- Masked sweep, en_mask=8'b1010_0101:
  - issue_valid only for channels 0, 2, 5, 7, on their fixed slots;
  - write-backs only for those channels;
  - done still at t+13.
- Tau configuration:
  - write tau[3]=32'h3DCCCCCD, then sweep → f_tau_out=32'h3DCCCCCD when issue_ch=3; all other channels show 32'h3D23D70A.
  - write cfg_addr=3 in the same cycle channel 3 issues → that cycle shows the old value.
- Overrun:
  - ticks at t and at t+5 (busy) and at t+13 (done cycle) → two drops, overrun=1, tick_drop_cnt=2.
  - tick at t+14 accepted.
  - force 70000 drops → tick_drop_cnt=0xFFFF.
- Reset mid-sweep: assert reset at t+6 for 2 cycles → all outputs 0; no wb_valid or done afterwards; next tick runs a clean sweep.
- Mask snapshot: toggle en_mask during ISSUE → issue pattern matches the mask sampled at the tick.

Source files
------------

// File: rtl/muscle_sweep_scheduler.sv
// muscle_sweep_scheduler: on each accepted tick, walks every muscle channel once, in
// index order, through a shared pipelined update datapath. It presents each
// channel's tau, raises the matching write-back strobe LAT cycles later, and
// reports sweep completion and dropped ticks.
module muscle_sweep_scheduler #(
  parameter int N_CH = 8,
  parameter int CH_W = 3,
  parameter int LAT  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic [N_CH-1:0] en_mask,
  input  logic            cfg_we,
  input  logic [CH_W-1:0] cfg_addr,
  input  logic [31:0]     cfg_data,
  output logic            issue_valid,
  output logic [CH_W-1:0] issue_ch,
  output logic [31:0]     f_tau_out,
  output logic            wb_valid,
  output logic [CH_W-1:0] wb_ch,
  output logic            busy,
  output logic            done,
  output logic            overrun,
  output logic [15:0]     tick_drop_cnt
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int DW = $clog2(LAT + 1);
  localparam logic [31:0] TAU_RESET = 32'h3D23D70A;  // 0.04 s

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t          state_reg, state_next;
  logic [CH_W-1:0] ch_cnt_reg, ch_cnt_next;
  logic [DW-1:0]   drain_cnt_reg, drain_cnt_next;
  logic [N_CH-1:0] mask_q_reg, mask_q_next;
  logic [31:0]     tau_reg [N_CH];

  logic            issue_valid_next;
  logic [CH_W-1:0] issue_ch_next;
  logic [31:0]     f_tau_next;
  logic [IW-1:0]   ch_idx_next;
  logic            tick_drop;

  logic            pipe_valid_reg [LAT];
  logic [CH_W-1:0] pipe_ch_reg    [LAT];

  // Sweep sequencing: snapshot the mask on an accepted tick, step one channel per
  // cycle (masked channels still burn their slot), then wait out the datapath.
  always_comb begin
    state_next     = state_reg;
    ch_cnt_next    = ch_cnt_reg;
    drain_cnt_next = drain_cnt_reg;
    mask_q_next    = mask_q_reg;
    case (state_reg)
      S_IDLE: begin
        if (tick) begin
          state_next  = S_ISSUE;
          ch_cnt_next = '0;
          mask_q_next = en_mask;
        end
      end
      S_ISSUE: begin
        if (ch_cnt_reg == CH_W'(N_CH - 1)) begin
          state_next     = S_DRAIN;
          drain_cnt_next = DW'(LAT);
        end else begin
          ch_cnt_next = ch_cnt_reg + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_reg == DW'(1)) state_next = S_DONE;
        else                         drain_cnt_next = drain_cnt_reg - 1'b1;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      ch_cnt_reg    <= '0;
      drain_cnt_reg <= '0;
      mask_q_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      ch_cnt_reg    <= ch_cnt_next;
      drain_cnt_reg <= drain_cnt_next;
      mask_q_reg    <= mask_q_next;
    end
  end

  // Issue-side values for the coming cycle. A tau write landing on the edge that
  // loads its channel is forwarded, so a write is always visible the next cycle.
  always_comb begin
    ch_idx_next      = ch_cnt_next[IW-1:0];
    issue_valid_next = (state_next == S_ISSUE) && mask_q_next[ch_idx_next];
    issue_ch_next    = (state_next == S_ISSUE) ? ch_cnt_next : '0;
    f_tau_next       = '0;
    if (issue_valid_next) begin
      if (cfg_we && (cfg_addr == ch_cnt_next)) f_tau_next = cfg_data;
      else                                     f_tau_next = tau_reg[ch_idx_next];
    end
  end

  assign tick_drop = tick && (state_reg != S_IDLE);

  // Registered outputs plus sticky drop tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_valid   <= 1'b0;
      issue_ch      <= '0;
      f_tau_out     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      overrun       <= 1'b0;
      tick_drop_cnt <= '0;
    end else begin
      issue_valid <= issue_valid_next;
      issue_ch    <= issue_ch_next;
      f_tau_out   <= f_tau_next;
      busy        <= (state_next != S_IDLE);
      done        <= (state_next == S_DONE);
      if (tick_drop) overrun <= 1'b1;
      if (tick_drop && (tick_drop_cnt != 16'hFFFF)) tick_drop_cnt <= tick_drop_cnt + 16'd1;
    end
  end

  // One tau register per channel. Matching against the channel number also
  // discards writes to addresses beyond the last channel.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_tau
    // Per-channel tau storage, reset to 0.04 s.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)                                    tau_reg[gi] <= TAU_RESET;
      else if (cfg_we && (32'(cfg_addr) == 32'(gi))) tau_reg[gi] <= cfg_data;
    end
  end

  // Write-back pipe: {valid, ch} delayed LAT cycles behind the issue outputs.
  for (genvar gi = 0; gi < LAT; gi++) begin : g_wb
    if (gi == 0) begin : g_head
      // First stage captures the issued channel.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pipe_valid_reg[gi] <= 1'b0;
          pipe_ch_reg[gi]    <= '0;
        end else begin
          pipe_valid_reg[gi] <= issue_valid;
          pipe_ch_reg[gi]    <= issue_ch;
        end
      end
    end else begin : g_body
      // Later stages shift the entry along.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pipe_valid_reg[gi] <= 1'b0;
          pipe_ch_reg[gi]    <= '0;
        end else begin
          pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
          pipe_ch_reg[gi]    <= pipe_ch_reg[gi-1];
        end
      end
    end
  end

  assign wb_valid = pipe_valid_reg[LAT-1];
  assign wb_ch    = pipe_ch_reg[LAT-1];

endmodule

// File: tb/tb_muscle_sweep_scheduler.sv
// Bench for muscle_sweep_scheduler: a cycle-level schedule model (sweep start time
// plus offset arithmetic) checked every cycle, a vector table for a masked sweep,
// and hand sequences for tau writes, overrun, saturation and mid-sweep reset.
module tb_muscle_sweep_scheduler;
  localparam int N = 8;
  localparam int L = 4;
  localparam int SWEEP = N + L + 2;
  localparam logic [31:0] TAU_DEF = 32'h3D23D70A;

  logic        clk = 1'b0;
  logic        reset, tick, cfg_we;
  logic [7:0]  en_mask;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        issue_valid, wb_valid, busy, done, overrun;
  logic [2:0]  issue_ch, wb_ch;
  logic [31:0] f_tau_out;
  logic [15:0] tick_drop_cnt;

  muscle_sweep_scheduler #(.N_CH(N), .CH_W(3), .LAT(L)) dut (
    .clk(clk), .reset(reset), .tick(tick), .en_mask(en_mask),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .issue_valid(issue_valid), .issue_ch(issue_ch), .f_tau_out(f_tau_out),
    .wb_valid(wb_valid), .wb_ch(wb_ch), .busy(busy), .done(done),
    .overrun(overrun), .tick_drop_cnt(tick_drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs = 0;
  int cyc = 0;
  bit verbose = 1'b1;

  // reference model state
  int          s_start;
  logic [7:0]  m_mask;
  logic [31:0] m_tau [N];
  bit          m_over;
  int          m_drops;

  // expected outputs after the current edge
  bit          x_iv, x_wv, x_busy, x_done, x_cmp_ich, x_cmp_wch;
  int          x_ich, x_wch;
  logic [31:0] x_tau;

  typedef struct {
    bit         tick;
    logic [7:0] mask;
    bit         iv;
    logic [2:0] ich;
    bit         wv;
    logic [2:0] wch;
    bit         busy;
    bit         done;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic void model_clear();
    s_start = -1000;
    m_mask  = '0;
    for (int i = 0; i < N; i++) m_tau[i] = TAU_DEF;
    m_over  = 1'b0;
    m_drops = 0;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int off, wi;
    cyc++;
    if (reset) begin
      model_clear();
      x_iv = 0; x_wv = 0; x_busy = 0; x_done = 0;
      x_ich = 0; x_wch = 0; x_tau = '0;
      x_cmp_ich = 1; x_cmp_wch = 1;
      return;
    end
    off = cyc - 1 - s_start;  // offset of the cycle that just ended
    if (tick) begin
      if (off >= 0 && off <= N + L) begin
        m_over = 1'b1;
        if (m_drops < 65535) m_drops++;
      end else begin
        s_start = cyc;
        m_mask  = en_mask;
        if (verbose) $display("cycle %0d: sweep accepted, mask %b", cyc, en_mask);
      end
    end
    if (cfg_we) m_tau[cfg_addr] = cfg_data;
    off = cyc - s_start;
    wi  = off - L;
    x_busy    = (off >= 0) && (off <= N + L);
    x_done    = (off == N + L);
    x_cmp_ich = (off >= 0) && (off < N);
    x_ich     = x_cmp_ich ? off : 0;
    x_iv      = x_cmp_ich && m_mask[off[2:0]];
    x_tau     = x_iv ? m_tau[off[2:0]] : 32'h0;
    x_wv      = (wi >= 0) && (wi < N) && m_mask[wi[2:0]];
    x_wch     = x_wv ? wi : 0;
    x_cmp_wch = x_wv;
  endtask

  task automatic check_outputs();
    chk("issue_valid", 32'(issue_valid), 32'(x_iv));
    if (x_cmp_ich) chk("issue_ch", 32'(issue_ch), 32'(x_ich));
    chk("f_tau_out", f_tau_out, x_tau);
    chk("wb_valid", 32'(wb_valid), 32'(x_wv));
    if (x_cmp_wch) chk("wb_ch", 32'(wb_ch), 32'(x_wch));
    chk("busy", 32'(busy), 32'(x_busy));
    chk("done", 32'(done), 32'(x_done));
    chk("overrun", 32'(overrun), 32'(m_over));
    chk("tick_drop_cnt", 32'(tick_drop_cnt), 32'(m_drops));
  endtask

  // One clock: inputs already set; model the edge, then sample at the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  function automatic vec_t mk(bit t, logic [7:0] m, bit iv, logic [2:0] ich,
                              bit wv, logic [2:0] wch, bit b, bit d);
    vec_t v;
    v.tick = t; v.mask = m; v.iv = iv; v.ich = ich;
    v.wv = wv; v.wch = wch; v.busy = b; v.done = d;
    return v;
  endfunction

  initial begin
    // Masked sweep 1010_0101; en_mask flips to 0101_1010 after the tick and must be ignored.
    tbl[0]  = mk(1, 8'hA5, 1, 3'd0, 0, 3'd0, 1, 0);
    tbl[1]  = mk(0, 8'h5A, 0, 3'd1, 0, 3'd0, 1, 0);
    tbl[2]  = mk(0, 8'h5A, 1, 3'd2, 0, 3'd0, 1, 0);
    tbl[3]  = mk(0, 8'h5A, 0, 3'd3, 0, 3'd0, 1, 0);
    tbl[4]  = mk(0, 8'h5A, 0, 3'd4, 1, 3'd0, 1, 0);
    tbl[5]  = mk(0, 8'h5A, 1, 3'd5, 0, 3'd0, 1, 0);
    tbl[6]  = mk(0, 8'h5A, 0, 3'd6, 1, 3'd2, 1, 0);
    tbl[7]  = mk(0, 8'h5A, 1, 3'd7, 0, 3'd0, 1, 0);
    tbl[8]  = mk(0, 8'h5A, 0, 3'd0, 0, 3'd0, 1, 0);
    tbl[9]  = mk(0, 8'h5A, 0, 3'd0, 1, 3'd5, 1, 0);
    tbl[10] = mk(0, 8'h5A, 0, 3'd0, 0, 3'd0, 1, 0);
    tbl[11] = mk(0, 8'h5A, 0, 3'd0, 1, 3'd7, 1, 0);
    tbl[12] = mk(0, 8'h5A, 0, 3'd0, 0, 3'd0, 1, 1);
    tbl[13] = mk(0, 8'h5A, 0, 3'd0, 0, 3'd0, 0, 0);

    reset = 1; tick = 0; en_mask = '0; cfg_we = 0; cfg_addr = '0; cfg_data = '0;
    model_clear();
    repeat (3) step();
    reset = 0;
    repeat (2) step();

    // Full sweep, all channels enabled.
    tick = 1; en_mask = 8'hFF; step();
    tick = 0; repeat (SWEEP) step();

    // Table-driven masked sweep with mask snapshot.
    for (int r = 0; r < 14; r++) begin
      tick = tbl[r].tick; en_mask = tbl[r].mask;
      step();
      chk("tbl_issue_valid", 32'(issue_valid), 32'(tbl[r].iv));
      if (tbl[r].iv) chk("tbl_issue_ch", 32'(issue_ch), 32'(tbl[r].ich));
      chk("tbl_wb_valid", 32'(wb_valid), 32'(tbl[r].wv));
      if (tbl[r].wv) chk("tbl_wb_ch", 32'(wb_ch), 32'(tbl[r].wch));
      chk("tbl_busy", 32'(busy), 32'(tbl[r].busy));
      chk("tbl_done", 32'(done), 32'(tbl[r].done));
    end
    tick = 0;

    // Tau configuration.
    cfg_we = 1; cfg_addr = 3'd3; cfg_data = 32'h3DCCCCCD; step();
    cfg_we = 0;
    tick = 1; en_mask = 8'hFF; step();           // ch0 issuing
    tick = 0; repeat (3) step();                 // ch3 issuing
    chk("tau_ch3_written", f_tau_out, 32'h3DCCCCCD);
    cfg_we = 1; cfg_addr = 3'd3; cfg_data = 32'h3E4CCCCD; step();  // write during ch3 slot; ch4 now
    cfg_addr = 3'd5; cfg_data = 32'h3E99999A; step();               // write lands as ch5 loads
    chk("tau_ch5_forwarded", f_tau_out, 32'h3E99999A);
    cfg_we = 0; repeat (8) step();               // back to idle
    tick = 1; step();
    tick = 0; repeat (3) step();
    chk("tau_ch3_after_collision", f_tau_out, 32'h3E4CCCCD);
    repeat (SWEEP - 4) step();

    // Overrun: ticks at t, t+5, t+13 (done cycle) and t+14.
    reset = 1; repeat (2) step();
    reset = 0; step();
    tick = 1; step();
    tick = 0; repeat (4) step();
    tick = 1; step();
    tick = 0; repeat (7) step();
    tick = 1; step();
    chk("overrun_cnt2", 32'(tick_drop_cnt), 32'd2);
    chk("overrun_flag", 32'(overrun), 32'd1);
    step();
    chk("tick_after_done_busy", 32'(busy), 32'd1);
    chk("tick_after_done_ch0", 32'(issue_valid), 32'd1);
    tick = 0; repeat (SWEEP) step();

    // Reset mid-sweep.
    tick = 1; en_mask = 8'hFF; step();
    tick = 0; repeat (5) step();
    reset = 1; step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset = 0; repeat (20) step();
    tick = 1; en_mask = 8'h3C; step();
    tick = 0; repeat (SWEEP) step();

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      tick     = ($urandom_range(0, 5) == 0);
      en_mask  = 8'($urandom);
      cfg_we   = ($urandom_range(0, 7) == 0);
      cfg_addr = 3'($urandom);
      cfg_data = $urandom;
      step();
    end
    tick = 0; cfg_we = 0;

    // Saturation of the drop counter: hold tick high.
    reset = 1; step();
    reset = 0; step();
    verbose = 1'b0;
    tick = 1;
    repeat (70900) step();
    tick = 0;
    chk("drop_cnt_saturated", 32'(tick_drop_cnt), 32'hFFFF);
    chk("drop_overrun", 32'(overrun), 32'd1);
    repeat (SWEEP) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
endmodule
